// File: rtl/elevator_scheduler_if.sv
// Request/status bundle between the button/lamp logic, the scheduler and the
// floor/door display blocks. The master side drives buttons and timing.
interface elevator_scheduler_if #(
    parameter int FLOORS = 6
);
    localparam int FW = $clog2(FLOORS);

    logic              tick;
    logic [FLOORS-1:0] req_up;
    logic [FLOORS-1:0] req_down;
    logic [FLOORS-1:0] req_cab;
    logic              door_hold;
    logic [FLOORS-1:0] pending_up;
    logic [FLOORS-1:0] pending_down;
    logic [FLOORS-1:0] pending_cab;
    logic [FW-1:0]     floor_idx;
    logic [FLOORS-1:0] floor_onehot;
    logic [1:0]        dir;
    logic              door_open;
    logic              moving;

    modport master (
        output tick, req_up, req_down, req_cab, door_hold,
        input  pending_up, pending_down, pending_cab, floor_idx, floor_onehot,
               dir, door_open, moving
    );

    modport slave (
        input  tick, req_up, req_down, req_cab, door_hold,
        output pending_up, pending_down, pending_cab, floor_idx, floor_onehot,
               dir, door_open, moving
    );
endinterface

// File: rtl/elevator_scheduler.sv
// Single-car SCAN elevator scheduler: latches hall/cab calls, sweeps in one
// direction while calls remain ahead, and runs a timed door cycle per stop.
module elevator_scheduler #(
    parameter int FLOORS     = 6,
    parameter int MOVE_TICKS = 2,
    parameter int DOOR_TICKS = 3
) (
    input logic                 clock,
    input logic                 reset_n,
    elevator_scheduler_if.slave bus
);
    localparam int FW = $clog2(FLOORS);
    localparam int MW = $clog2(MOVE_TICKS + 1);
    localparam int DW = $clog2(DOOR_TICKS + 1);
    localparam logic [FLOORS-1:0] ONE       = FLOORS'(1);
    localparam logic [FLOORS-1:0] UP_MASK   = ~(ONE << (FLOORS - 1));
    localparam logic [FLOORS-1:0] DOWN_MASK = ~ONE;
    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

    state_t            state, state_n;
    logic [1:0]        dir, dir_n;
    logic [FW-1:0]     floor_q, floor_n, nf;
    logic [FLOORS-1:0] floor_oh, nf_oh;
    logic [MW-1:0]     move_cnt, move_cnt_n;
    logic [DW-1:0]     door_cnt, door_cnt_n;
    logic [FLOORS-1:0] pending_up, pending_down, pending_cab;
    logic [FLOORS-1:0] rup, rdn, rcab, here_mask;
    logic [FLOORS-1:0] p_up, p_dn, p_cab, p_all;
    logic [FLOORS-1:0] clr_up, clr_dn, clr_cab;
    logic              absorb, up_ahead, dn_ahead, nf_beyond;

    function automatic logic any_above(input logic [FLOORS-1:0] v, input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++)
            if (i > int'(f) && v[i]) r = 1'b1;
        return r;
    endfunction

    function automatic logic any_below(input logic [FLOORS-1:0] v, input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++)
            if (i < int'(f) && v[i]) r = 1'b1;
        return r;
    endfunction

    function automatic logic beyond(input logic [FLOORS-1:0] v, input logic [FW-1:0] f,
                                    input logic [1:0] d);
        if (d == DIR_UP)   return any_above(v, f);
        if (d == DIR_DOWN) return any_below(v, f);
        return 1'b0;
    endfunction

    // Saturating one-floor step; the ends never wrap.
    function automatic logic [FW-1:0] step_floor(input logic [FW-1:0] f, input logic [1:0] d);
        if (d == DIR_UP && int'(f) < FLOORS - 1) return f + 1'b1;
        if (d == DIR_DOWN && f != '0)            return f - 1'b1;
        return f;
    endfunction

    // Next-state, sweep decisions and per-stop clear masks.
    always_comb begin
        rup        = bus.req_up & UP_MASK;
        rdn        = bus.req_down & DOWN_MASK;
        rcab       = bus.req_cab;
        // With the car parked or the door open, a call at this floor is served
        // on the spot instead of being queued.
        here_mask  = (state == MOVE) ? '0 : floor_oh;
        absorb     = |((rup | rdn | rcab) & here_mask);
        p_up       = pending_up   | (rup  & ~here_mask);
        p_dn       = pending_down | (rdn  & ~here_mask);
        p_cab      = pending_cab  | (rcab & ~here_mask);
        p_all      = p_up | p_dn | p_cab;
        up_ahead   = any_above(p_all, floor_q);
        dn_ahead   = any_below(p_all, floor_q);
        nf         = step_floor(floor_q, dir);
        nf_oh      = ONE << nf;
        nf_beyond  = beyond(p_all, nf, dir);
        state_n    = state;
        dir_n      = dir;
        floor_n    = floor_q;
        move_cnt_n = move_cnt;
        door_cnt_n = door_cnt;
        clr_up     = '0;
        clr_dn     = '0;
        clr_cab    = '0;
        case (state)
            IDLE: begin
                if (absorb || |(p_all & floor_oh)) begin
                    state_n    = DOOR;
                    door_cnt_n = DW'(DOOR_TICKS);
                    clr_up     = floor_oh;
                    clr_dn     = floor_oh;
                    clr_cab    = floor_oh;
                end else if (up_ahead) begin
                    dir_n      = DIR_UP;
                    state_n    = MOVE;
                    move_cnt_n = '0;
                end else if (dn_ahead) begin
                    dir_n      = DIR_DOWN;
                    state_n    = MOVE;
                    move_cnt_n = '0;
                end
            end
            MOVE: begin
                if (bus.tick) begin
                    if (move_cnt == MW'(MOVE_TICKS - 1)) begin
                        move_cnt_n = '0;
                        floor_n    = nf;
                        // Nothing left ahead also covers arriving at an end floor.
                        if (|(p_cab & nf_oh) || (dir == DIR_UP && |(p_up & nf_oh)) ||
                            (dir == DIR_DOWN && |(p_dn & nf_oh)) || !nf_beyond) begin
                            state_n    = DOOR;
                            door_cnt_n = DW'(DOOR_TICKS);
                            clr_cab    = nf_oh;
                            if (dir == DIR_UP || !nf_beyond)   clr_up = nf_oh;
                            if (dir == DIR_DOWN || !nf_beyond) clr_dn = nf_oh;
                        end
                    end else begin
                        move_cnt_n = move_cnt + 1'b1;
                    end
                end
            end
            DOOR: begin
                if (bus.door_hold || absorb) begin
                    door_cnt_n = DW'(DOOR_TICKS);
                end else if (bus.tick) begin
                    if (door_cnt > DW'(1)) begin
                        door_cnt_n = door_cnt - 1'b1;
                    end else begin
                        door_cnt_n = '0;
                        move_cnt_n = '0;
                        if (dir == DIR_UP && up_ahead) begin
                            state_n = MOVE;
                        end else if (dir == DIR_DOWN && dn_ahead) begin
                            state_n = MOVE;
                        end else if (dir == DIR_UP && dn_ahead) begin
                            // Turning around: a waiting down call here is served by this stop.
                            dir_n = DIR_DOWN;
                            if (|(p_dn & floor_oh)) begin
                                clr_dn     = floor_oh;
                                door_cnt_n = DW'(DOOR_TICKS);
                            end else begin
                                state_n = MOVE;
                            end
                        end else if (dir == DIR_DOWN && up_ahead) begin
                            dir_n = DIR_UP;
                            if (|(p_up & floor_oh)) begin
                                clr_up     = floor_oh;
                                door_cnt_n = DW'(DOOR_TICKS);
                            end else begin
                                state_n = MOVE;
                            end
                        end else if (dir == DIR_IDLE && up_ahead) begin
                            dir_n   = DIR_UP;
                            state_n = MOVE;
                        end else if (dir == DIR_IDLE && dn_ahead) begin
                            dir_n   = DIR_DOWN;
                            state_n = MOVE;
                        end else begin
                            dir_n   = DIR_IDLE;
                            state_n = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
                dir_n   = DIR_IDLE;
            end
        endcase
    end

    // State, position, timers and call queues; a new call beats a same-cycle clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            dir          <= DIR_IDLE;
            floor_q      <= '0;
            floor_oh     <= ONE;
            move_cnt     <= '0;
            door_cnt     <= '0;
            pending_up   <= '0;
            pending_down <= '0;
            pending_cab  <= '0;
        end else begin
            state        <= state_n;
            dir          <= dir_n;
            floor_q      <= floor_n;
            floor_oh     <= ONE << floor_n;
            move_cnt     <= move_cnt_n;
            door_cnt     <= door_cnt_n;
            pending_up   <= (pending_up   & ~clr_up)  | (rup  & ~here_mask);
            pending_down <= (pending_down & ~clr_dn)  | (rdn  & ~here_mask);
            pending_cab  <= (pending_cab  & ~clr_cab) | (rcab & ~here_mask);
        end
    end

    assign bus.pending_up   = pending_up;
    assign bus.pending_down = pending_down;
    assign bus.pending_cab  = pending_cab;
    assign bus.floor_idx    = floor_q;
    assign bus.floor_onehot = floor_oh;
    assign bus.dir          = dir;
    assign bus.door_open    = (state == DOOR);
    assign bus.moving       = (state == MOVE);
endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler (6 floors, 2 ticks per floor, 3 door ticks).
module tb_elevator_scheduler;
    localparam int FLOORS = 6;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   exp_q[$];
    int   obs_q[$];
    logic door_prev = 1'b0;

    always #5 clock = ~clock;

    elevator_scheduler_if #(.FLOORS(FLOORS)) bus ();

    elevator_scheduler #(.FLOORS(FLOORS), .MOVE_TICKS(2), .DOOR_TICKS(3)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Every door opening is recorded as an observed stop.
    always @(negedge clock) begin
        if (bus.door_open && !door_prev) obs_q.push_back(int'(bus.floor_idx));
        door_prev <= bus.door_open;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse(input logic [5:0] up, input logic [5:0] dn, input logic [5:0] cab);
        bus.req_up   = up;
        bus.req_down = dn;
        bus.req_cab  = cab;
        step();
        bus.req_up   = '0;
        bus.req_down = '0;
        bus.req_cab  = '0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (!bus.moving && !bus.door_open && bus.dir == 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++;
        if (bus.floor_idx !== 3'd0 || bus.floor_onehot !== 6'b000001) begin
            errors++;
            $display("FAIL reset_floor: got idx=%0d onehot=%b, want 0/000001", bus.floor_idx, bus.floor_onehot);
        end
        checks++;
        if (bus.dir !== 2'b00 || bus.door_open !== 1'b0 || bus.moving !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got dir=%b door=%b moving=%b, want 00/0/0", bus.dir, bus.door_open, bus.moving);
        end
        checks++;
        if ((bus.pending_up | bus.pending_down | bus.pending_cab) !== 6'b0) begin
            errors++;
            $display("FAIL reset_pending: got %b/%b/%b, want all zero", bus.pending_up, bus.pending_down, bus.pending_cab);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single_cab();
        int e, o;
        bit ok;
        exp_q.push_back(2);
        pulse(6'b0, 6'b0, 6'b000100);
        checks++;
        if (bus.dir !== 2'b01 || bus.moving !== 1'b1 || bus.pending_cab !== 6'b000100) begin
            errors++;
            $display("FAIL cab_start: got dir=%b moving=%b cab=%b, want 01/1/000100", bus.dir, bus.moving, bus.pending_cab);
        end
        step(); step();
        checks++;
        if (bus.floor_idx !== 3'd1 || bus.floor_onehot !== 6'b000010) begin
            errors++;
            $display("FAIL cab_floor1: got idx=%0d onehot=%b, want 1/000010", bus.floor_idx, bus.floor_onehot);
        end
        step(); step();
        checks++;
        if (bus.floor_idx !== 3'd2 || bus.door_open !== 1'b1 || bus.pending_cab !== 6'b0) begin
            errors++;
            $display("FAIL cab_arrive: got idx=%0d door=%b cab=%b, want 2/1/000000", bus.floor_idx, bus.door_open, bus.pending_cab);
        end
        step(); step();
        checks++;
        if (bus.door_open !== 1'b1) begin
            errors++;
            $display("FAIL cab_door_third: got door=%b, want 1", bus.door_open);
        end
        step();
        checks++;
        if (bus.door_open !== 1'b0 || bus.dir !== 2'b00 || bus.moving !== 1'b0 || bus.floor_idx !== 3'd2) begin
            errors++;
            $display("FAIL cab_idle: got door=%b dir=%b moving=%b idx=%0d, want 0/00/0/2",
                     bus.door_open, bus.dir, bus.moving, bus.floor_idx);
        end
        wait_idle(10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL cab_timeout: car not idle within 10 cycles"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL cab_stop: got no stop, want floor %0d", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL cab_stop: got floor %0d, want %0d", o, e); end
            end
        end
    endtask

    task automatic test_pass_through();
        int e, o;
        bit ok, seen_pass;
        seen_pass = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        exp_q.push_back(4);
        exp_q.push_back(2);
        pulse(6'b0, 6'b000100, 6'b010000);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (bus.moving && bus.dir == 2'b01 && bus.floor_idx == 3'd2 && !seen_pass) begin
                seen_pass = 1'b1;
                checks++;
                if (bus.pending_down[2] !== 1'b1) begin
                    errors++;
                    $display("FAIL pass_keep_down2: got %b while passing floor 2, want 1", bus.pending_down[2]);
                end
            end
            if (bus.door_open && bus.floor_idx == 3'd2) begin
                checks++;
                if (bus.pending_down[2] !== 1'b0) begin
                    errors++;
                    $display("FAIL pass_clear_down2: got %b at stop 2, want 0", bus.pending_down[2]);
                end
            end
            if (!bus.moving && !bus.door_open && bus.dir == 2'b00) begin ok = 1'b1; break; end
            step();
        end
        checks++;
        if (!ok || !seen_pass) begin
            errors++;
            $display("FAIL pass_progress: got idle=%0d passed2=%0d, want 1/1", ok, seen_pass);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL pass_stop: got no stop, want floor %0d", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL pass_stop: got floor %0d, want %0d", o, e); end
            end
        end
    endtask

    task automatic test_hold();
        int e, o, open_cycles;
        bit ok;
        exp_q.push_back(3);
        pulse(6'b0, 6'b0, 6'b001000);
        wait_idle(40, ok);
        checks++;
        if (!ok || bus.floor_idx !== 3'd3) begin
            errors++;
            $display("FAIL hold_setup: got idle=%0d idx=%0d, want 1/3", ok, bus.floor_idx);
        end
        exp_q.push_back(3);
        pulse(6'b001000, 6'b0, 6'b0);
        checks++;
        if (bus.door_open !== 1'b1 || bus.pending_up !== 6'b0) begin
            errors++;
            $display("FAIL hold_absorb: got door=%b up=%b, want 1/000000", bus.door_open, bus.pending_up);
        end
        open_cycles = 1;
        bus.door_hold = 1'b1;
        repeat (5) begin
            step();
            if (bus.door_open) open_cycles++;
        end
        bus.door_hold = 1'b0;
        for (int i = 0; i < 20 && bus.door_open; i++) begin
            step();
            if (bus.door_open) open_cycles++;
        end
        checks++;
        if (open_cycles !== 8) begin
            errors++;
            $display("FAIL hold_open_time: got %0d open cycles, want 8", open_cycles);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL hold_stop: got no stop, want floor %0d", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL hold_stop: got floor %0d, want %0d", o, e); end
            end
        end
    endtask

    task automatic test_masked();
        int busy;
        busy = 0;
        pulse(6'b100000, 6'b000001, 6'b0);
        checks++;
        if (bus.pending_up !== 6'b0 || bus.pending_down !== 6'b0) begin
            errors++;
            $display("FAIL masked_pending: got up=%b down=%b, want 000000/000000", bus.pending_up, bus.pending_down);
        end
        repeat (6) begin
            step();
            if (bus.moving || bus.door_open || bus.dir != 2'b00 || bus.floor_idx != 3'd3) busy++;
        end
        checks++;
        if (busy !== 0) begin
            errors++;
            $display("FAIL masked_idle: got %0d non-idle cycles, want 0", busy);
        end
    endtask

    task automatic test_reset_mid_travel();
        bit ok;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        pulse(6'b001000, 6'b0, 6'b010000);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.moving && bus.floor_idx == 3'd1) begin ok = 1'b1; break; end
            step();
        end
        step();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (!ok || bus.floor_idx !== 3'd0 || bus.moving !== 1'b0 || bus.floor_onehot !== 6'b000001) begin
            errors++;
            $display("FAIL async_reset_pos: got reached1=%0d idx=%0d moving=%b onehot=%b, want 1/0/0/000001",
                     ok, bus.floor_idx, bus.moving, bus.floor_onehot);
        end
        checks++;
        if ((bus.pending_up | bus.pending_down | bus.pending_cab) !== 6'b0 || bus.dir !== 2'b00) begin
            errors++;
            $display("FAIL async_reset_queue: got %b/%b/%b dir=%b, want zeros/00",
                     bus.pending_up, bus.pending_down, bus.pending_cab, bus.dir);
        end
        checks++;
        if (obs_q.size() !== 0) begin
            errors++;
            $display("FAIL async_reset_stops: got %0d stops before reset, want 0", obs_q.size());
        end
        step();
        reset_n = 1'b1;
        repeat (4) step();
        checks++;
        if (bus.moving !== 1'b0 || bus.door_open !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_lost: got moving=%b door=%b, want 0/0", bus.moving, bus.door_open);
        end
    endtask

    task automatic test_tick_stall();
        int e, o, drift;
        bit ok;
        drift = 0;
        exp_q.push_back(1);
        pulse(6'b0, 6'b0, 6'b000010);
        bus.tick = 1'b0;
        repeat (20) begin
            step();
            if (bus.floor_idx != 3'd0 || !bus.moving) drift++;
        end
        checks++;
        if (drift !== 0) begin
            errors++;
            $display("FAIL stall_hold: got %0d cycles off floor 0 or not moving, want 0", drift);
        end
        bus.tick = 1'b1;
        step();
        checks++;
        if (bus.floor_idx !== 3'd0 || bus.moving !== 1'b1) begin
            errors++;
            $display("FAIL stall_tick1: got idx=%0d moving=%b, want 0/1", bus.floor_idx, bus.moving);
        end
        step();
        checks++;
        if (bus.floor_idx !== 3'd1 || bus.door_open !== 1'b1) begin
            errors++;
            $display("FAIL stall_arrive: got idx=%0d door=%b, want 1/1", bus.floor_idx, bus.door_open);
        end
        wait_idle(20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_timeout: car not idle within 20 cycles"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL stall_stop: got no stop, want floor %0d", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL stall_stop: got floor %0d, want %0d", o, e); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int e, o;
        bit ok;
        exp_q.push_back(3);
        exp_q.push_back(5);
        exp_q.push_back(2);
        pulse(6'b001000, 6'b000100, 6'b100000);
        wait_idle(120, ok);
        checks++;
        if (!ok || bus.floor_idx !== 3'd2) begin
            errors++;
            $display("FAIL sweep_end: got idle=%0d idx=%0d, want 1/2", ok, bus.floor_idx);
        end
        checks++;
        if ((bus.pending_up | bus.pending_down | bus.pending_cab) !== 6'b0) begin
            errors++;
            $display("FAIL sweep_cleared: got %b/%b/%b, want all zero", bus.pending_up, bus.pending_down, bus.pending_cab);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL sweep_stop: got no stop, want floor %0d", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL sweep_stop: got floor %0d, want %0d", o, e); end
            end
        end
        checks++;
        if (obs_q.size() !== 0) begin
            errors++;
            $display("FAIL sweep_extra: got %0d unexpected stops, want 0", obs_q.size());
        end
    endtask

    initial begin
        bus.tick      = 1'b1;
        bus.req_up    = '0;
        bus.req_down  = '0;
        bus.req_cab   = '0;
        bus.door_hold = 1'b0;
        test_reset();
        test_single_cab();
        test_pass_through();
        test_hold();
        test_masked();
        test_reset_mid_travel();
        test_tick_stall();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
